// File: rtl/asm_turn_ctrl.sv
// Two-player turn scheduler for the shared row/col lookup datapath.
// Alternates turns, gathers coordinate presses under a beat timeout, scores lookup hits.
module asm_turn_ctrl #(
  parameter int TIMEOUT_BEATS = 8,
  parameter int SHOW_BEATS    = 2,
  parameter int ROUNDS        = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       beat_i,
  input  logic       enter_i,
  input  logic       r_btn_i,
  input  logic       c_btn_i,
  input  logic       lk_hit_i,
  output logic [2:0] lk_row_o,
  output logic [2:0] lk_col_o,
  output logic       lk_valid_o,
  output logic       player_o,
  output logic [2:0] state_led_o,
  output logic [3:0] score0_o,
  output logic [3:0] score1_o,
  output logic [1:0] winner_o,
  output logic       done_o
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'b000,
    S_TURN  = 3'b001,
    S_CHECK = 3'b010,
    S_SHOW  = 3'b011,
    S_DONE  = 3'b100
  } state_e;

  localparam logic [3:0] TURN_LAST  = 4'(TIMEOUT_BEATS - 1);
  localparam logic [3:0] SHOW_LAST  = 4'(SHOW_BEATS - 1);
  localparam logic [3:0] ROUND_LAST = 4'(ROUNDS - 1);

  state_e     state_q, state_d;
  logic       player_q, player_d;
  logic [3:0] round_q, round_d;
  logic [2:0] row_q, row_d;
  logic [2:0] col_q, col_d;
  logic [3:0] beat_cnt_q, beat_cnt_d;
  logic [3:0] score0_q, score0_d;
  logic [3:0] score1_q, score1_d;
  logic       lk_valid;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      player_q   <= 1'b0;
      round_q    <= 4'd0;
      row_q      <= 3'd0;
      col_q      <= 3'd0;
      beat_cnt_q <= 4'd0;
      score0_q   <= 4'd0;
      score1_q   <= 4'd0;
    end else begin
      state_q    <= state_d;
      player_q   <= player_d;
      round_q    <= round_d;
      row_q      <= row_d;
      col_q      <= col_d;
      beat_cnt_q <= beat_cnt_d;
      score0_q   <= score0_d;
      score1_q   <= score1_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    player_d   = player_q;
    round_d    = round_q;
    row_d      = row_q;
    col_d      = col_q;
    beat_cnt_d = beat_cnt_q;
    score0_d   = score0_q;
    score1_d   = score1_q;
    lk_valid   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (enter_i) begin
          state_d    = S_TURN;
          player_d   = 1'b0;
          round_d    = 4'd0;
          row_d      = 3'd0;
          col_d      = 3'd0;
          beat_cnt_d = 4'd0;
          score0_d   = 4'd0;
          score1_d   = 4'd0;
        end
      end
      S_TURN: begin
        if (r_btn_i) row_d = row_q + 3'd1;
        if (c_btn_i) col_d = col_q + 3'd1;
        // A commit on the same cycle as the final timeout beat still gets checked.
        if (enter_i) begin
          state_d = S_CHECK;
        end else if (beat_i) begin
          if (beat_cnt_q == TURN_LAST) begin
            state_d    = S_SHOW;
            beat_cnt_d = 4'd0;
          end else begin
            beat_cnt_d = beat_cnt_q + 4'd1;
          end
        end
      end
      S_CHECK: begin
        lk_valid   = 1'b1;
        state_d    = S_SHOW;
        beat_cnt_d = 4'd0;
        if (lk_hit_i) begin
          if (player_q && score1_q != 4'd15) score1_d = score1_q + 4'd1;
          if (!player_q && score0_q != 4'd15) score0_d = score0_q + 4'd1;
        end
      end
      S_SHOW: begin
        if (beat_i) begin
          if (beat_cnt_q == SHOW_LAST) begin
            row_d      = 3'd0;
            col_d      = 3'd0;
            beat_cnt_d = 4'd0;
            if (!player_q) begin
              player_d = 1'b1;
              state_d  = S_TURN;
            end else if (round_q == ROUND_LAST) begin
              state_d = S_DONE;
            end else begin
              player_d = 1'b0;
              round_d  = round_q + 4'd1;
              state_d  = S_TURN;
            end
          end else begin
            beat_cnt_d = beat_cnt_q + 4'd1;
          end
        end
      end
      S_DONE: begin
        if (enter_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    winner_o = 2'b00;
    if (state_q == S_DONE) begin
      if (score0_q > score1_q)      winner_o = 2'b01;
      else if (score1_q > score0_q) winner_o = 2'b10;
      else                          winner_o = 2'b11;
    end
  end

  assign lk_row_o    = row_q;
  assign lk_col_o    = col_q;
  assign lk_valid_o  = lk_valid;
  assign player_o    = player_q;
  assign state_led_o = state_q;
  assign score0_o    = score0_q;
  assign score1_o    = score1_q;
  assign done_o      = (state_q == S_DONE);

endmodule

// File: doc/asm_turn_ctrl.md
# asm_turn_ctrl

Two-player turn scheduler for the shared coordinate-lookup datapath (row/col into the character-reference lookup, seven-segment out). Alternates ownership of the lookup between player 0 and player 1, collects each player's row/col button presses under a beat-based timeout, and issues a one-cycle lookup request on commit. Scores hits and runs a fixed number of rounds. Sits between the board's button/beat sources and the lookup/display block.

## Interface
Parameters:
- TIMEOUT_BEATS, 8: beats allowed per turn before forced miss (≥1)
- SHOW_BEATS, 2: beats the committed coordinate is held on display (≥1)
- ROUNDS, 4: rounds per game; one round = one turn per player (1..15)

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- beat  in  1  one-cycle tick from beat generator
- enter  in  1  one-cycle pulse, pre-debounced
- r_btn  in  1  one-cycle pulse, increment row
- c_btn  in  1  one-cycle pulse, increment column
- lk_hit  in  1  combinational lookup result for lk_row/lk_col, valid while lk_valid=1
- lk_row  out  3  row presented to lookup/display
- lk_col  out  3  column presented to lookup/display
- lk_valid  out  1  one-cycle lookup request (CHECK state)
- player  out  1  current turn owner
- state_led  out  3  IDLE=000, TURN=001, CHECK=010, SHOW=011, DONE=100
- score0, score1  out  4  per-player hit counts, saturate at 15
- winner  out  2  in DONE: 01 p0, 10 p1, 11 tie; else 00
- done  out  1  high in DONE

## Operation
- Registers: state, player, round (4b), row_reg/col_reg (3b), beat_cnt (4b), score0/score1.
- lk_row/lk_col are row_reg/col_reg directly in all states.
- IDLE: enter → TURN; player, round, scores, row_reg, col_reg, beat_cnt cleared on that transition.
- TURN: r_btn → row_reg+1, c_btn → col_reg+1, both mod 8 (7→0); simultaneous presses both apply. beat → beat_cnt+1. enter → CHECK. beat with beat_cnt==TIMEOUT_BEATS-1 → SHOW, no score (timeout miss). enter and timeout beat in same cycle: enter wins.
- CHECK (exactly one cycle): lk_valid=1; if lk_hit, score[player] += 1 (hold at 15). → SHOW. beat_cnt cleared.
- SHOW: buttons and enter ignored; beat → beat_cnt+1; beat with beat_cnt==SHOW_BEATS-1 ends turn:
  - player 0 → player=1, TURN.
  - player 1 and round==ROUNDS-1 → DONE.
  - player 1 otherwise → player=0, round+1, TURN.
  - on every turn end: row_reg, col_reg, beat_cnt cleared.
- DONE: winner from score compare; enter → IDLE (scores held until next IDLE exit).
- r_btn/c_btn ignored outside TURN; beat ignored in IDLE, CHECK, DONE.

## Timing
- Reset: state=IDLE, all outputs 0 (lk_valid=0, player=0, scores=0, winner=00, done=0, lk_row=lk_col=0).
- Reset mid-game: next cycle IDLE, all registers cleared, no pending request.
- Transitions take effect the cycle after the causing pulse is sampled.
- Commit latency: enter sampled in TURN at cycle N → lk_valid=1 at N+1 → updated score visible at N+2.
- Button press in TURN at cycle N → lk_row/lk_col updated at N+1.
- Turn timeout: exactly TIMEOUT_BEATS beats after entering TURN.
- SHOW duration: exactly SHOW_BEATS beats.
- winner/done valid the cycle state enters DONE.

## Test plan
- Reset then enter → state_led=001, player=0, lk_row=lk_col=0, scores 0.
- P0: 3× r_btn, 9× c_btn, enter with lk_hit tied 1 when (3,1) → lk_valid one cycle with lk_row=3, lk_col=1; score0=1 two cycles after enter; after 2 beats player=1, coords 0.
- P1 idles 8 beats → SHOW without lk_valid, score1 unchanged; enter on the 8th beat's cycle → CHECK instead.
- Full game ROUNDS=4, P0 hits every turn, P1 misses → DONE after 8 turns, score0=4, score1=0, winner=01, done=1; enter → IDLE.
- Reset asserted during CHECK and SHOW → IDLE next cycle, scores 0, lk_valid 0; score saturation with ROUNDS=15 forced hits and score preset via 15+ hits holds at 15.
